// File: rtl/expander.sv
// SPI-slave GPIO expander on an 8-in/8-out pin bus.
// A host drives two-byte transactions (command, then data) over SPI mode 0
// with an active-high select. The transactions read and write a small
// register file that controls a 7-bit output port and samples a 2-bit input
// port. Every SPI pin is oversampled on the system clock, so the whole
// design lives in a single clock domain.
module expander #(
    parameter int SYNC_STAGES = 2
) (
    input  logic [7:0] io_in,
    output logic [7:0] io_out
);

    typedef enum logic {
        PH_CMD,
        PH_DATA
    } phase_t;

    logic clk;
    logic rst_n;
    logic unused_pin;

    assign clk        = io_in[4];
    assign rst_n      = io_in[7];
    assign unused_pin = io_in[2];

    logic [SYNC_STAGES-1:0]      ss_sync;
    logic [SYNC_STAGES-1:0]      sclk_sync;
    logic [SYNC_STAGES-1:0]      mosi_sync;
    logic [SYNC_STAGES-1:0][1:0] gpio_sync;

    logic       ss_s, sclk_s, mosi_s;
    logic [1:0] gpio_s;
    logic       ss_q, sclk_q;
    logic       ss_rise, ss_fall, sclk_rise, sclk_fall;

    logic [3:0] bit_cnt;
    logic [7:0] rx_sr;
    logic       byte_done;

    phase_t     phase;
    logic [7:0] cmd;
    logic [7:0] ctrl;
    logic [7:0] out_r;

    logic [7:0] tx_sr;
    logic       rd_active;
    logic [7:0] rd_sel;

    assign ss_s   = ss_sync[SYNC_STAGES-1];
    assign sclk_s = sclk_sync[SYNC_STAGES-1];
    assign mosi_s = mosi_sync[SYNC_STAGES-1];
    assign gpio_s = gpio_sync[SYNC_STAGES-1];

    assign ss_rise   =  ss_s   & ~ss_q;
    assign ss_fall   = ~ss_s   &  ss_q;
    assign sclk_rise =  sclk_s & ~sclk_q;
    assign sclk_fall = ~sclk_s &  sclk_q;

    // Synchronise the asynchronous pins and keep one extra sample for edge detection.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ss_sync   <= '0;
            sclk_sync <= '0;
            mosi_sync <= '0;
            gpio_sync <= '0;
            ss_q      <= 1'b0;
            sclk_q    <= 1'b0;
        end else begin
            ss_sync   <= {ss_sync[SYNC_STAGES-2:0], io_in[0]};
            sclk_sync <= {sclk_sync[SYNC_STAGES-2:0], io_in[1]};
            mosi_sync <= {mosi_sync[SYNC_STAGES-2:0], io_in[3]};
            gpio_sync <= {gpio_sync[SYNC_STAGES-2:0], io_in[6:5]};
            ss_q      <= ss_s;
            sclk_q    <= sclk_s;
        end
    end

    // Assemble the incoming byte. The counter stops at 8, so any clocks
    // after the eighth in the same frame are ignored.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bit_cnt   <= 4'd0;
            rx_sr     <= 8'h00;
            byte_done <= 1'b0;
        end else begin
            byte_done <= ~ss_rise & ss_s & sclk_rise & (bit_cnt == 4'd7);
            if (ss_rise) begin
                bit_cnt <= 4'd0;
                rx_sr   <= 8'h00;
            end else if (ss_s && sclk_rise && bit_cnt != 4'd8) begin
                rx_sr   <= {rx_sr[6:0], mosi_s};
                bit_cnt <= bit_cnt + 4'd1;
            end
        end
    end

    // Run the command/data phase machine and commit writes to the register file.
    // When SRST is set, it wipes CTRL and OUT one clock after the write lands.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            phase <= PH_CMD;
            cmd   <= 8'h00;
            ctrl  <= 8'h00;
            out_r <= 8'h00;
        end else begin
            if (ctrl[0]) begin
                ctrl  <= 8'h00;
                out_r <= 8'h00;
            end
            if (byte_done) begin
                case (phase)
                    PH_CMD: begin
                        cmd   <= rx_sr;
                        phase <= PH_DATA;
                    end
                    PH_DATA: begin
                        if (cmd[7]) begin
                            case (cmd[1:0])
                                2'b00:   ctrl  <= rx_sr;
                                2'b11:   out_r <= rx_sr;
                                default: ;
                            endcase
                        end
                        phase <= PH_CMD;
                    end
                    default: phase <= PH_CMD;
                endcase
            end
        end
    end

    // Select the register that a read data frame returns.
    always_comb begin
        rd_sel = 8'h00;
        case (cmd[1:0])
            2'b00:   rd_sel = ctrl;
            2'b01:   rd_sel = {6'b0, gpio_s};
            2'b10:   rd_sel = 8'h00;
            default: rd_sel = out_r;
        endcase
    end

    // Load the read value when a read data frame is selected, then shift it
    // out MSB first, advancing on each falling sclk edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tx_sr     <= 8'h00;
            rd_active <= 1'b0;
        end else if (ss_rise) begin
            rd_active <= (phase == PH_DATA) && !cmd[7];
            tx_sr     <= rd_sel;
        end else if (ss_fall) begin
            rd_active <= 1'b0;
        end else if (ss_s && sclk_fall) begin
            tx_sr <= {tx_sr[6:0], 1'b0};
        end
    end

    assign io_out = {(ctrl[3] ? out_r[6:0] : 7'd0), rd_active & tx_sr[7]};

endmodule

// File: tb/tb_expander.sv
// Directed bench for the SPI GPIO expander: table of two-byte transactions
// plus hand-written sequences for partial frames, soft reset and reset mid-transaction.
`timescale 1ns/1ps
module tb_expander;

    logic       clk   = 1'b0;
    logic       rst_n = 1'b0;
    logic       ss    = 1'b0;
    logic       sclk  = 1'b0;
    logic       mosi  = 1'b0;
    logic       spare = 1'b0;
    logic [1:0] gpio  = 2'b00;
    logic [7:0] io_in;
    logic [7:0] io_out;

    assign io_in = {rst_n, gpio, clk, mosi, spare, sclk, ss};

    always #5 clk = ~clk;

    expander #(.SYNC_STAGES(2)) dut (
        .io_in (io_in),
        .io_out(io_out)
    );

    int total = 0;
    int bad   = 0;
    logic [7:0] snap4;
    logic [7:0] snap5;
    logic [7:0] rdv;
    logic [7:0] dummy;

    typedef struct {
        logic [7:0] cmd;
        logic [7:0] data;
        bit         rd;
        logic [7:0] exp_rd;
        logic [7:0] exp_io;
    } vec_t;

    vec_t vecs[14];

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%02h expected 0x%02h", name, act, exp);
        end
    endtask

    task automatic wait_clk(input int n);
        repeat (n) @(negedge clk);
    endtask

    // One SPI frame of nbits clocks; returns the miso bits sampled before each rise.
    // snap4/snap5 hold io_out 4 and 5 clocks after the last sclk rise.
    task automatic frame(input logic [7:0] tx, input int nbits, output logic [7:0] rx);
        rx = 8'h00;
        ss = 1'b1;
        wait_clk(5);
        for (int i = 0; i < nbits; i++) begin
            mosi = tx[7-i];
            wait_clk(4);
            rx = {rx[6:0], io_out[0]};
            sclk = 1'b1;
            if (i == nbits - 1) begin
                wait_clk(4);
                snap4 = io_out;
                wait_clk(1);
                snap5 = io_out;
                wait_clk(3);
            end else begin
                wait_clk(4);
            end
            sclk = 1'b0;
        end
        wait_clk(4);
        ss   = 1'b0;
        mosi = 1'b0;
        wait_clk(5);
    endtask

    task automatic txn(input logic [7:0] c, input logic [7:0] d, output logic [7:0] r);
        logic [7:0] tmp;
        frame(c, 8, tmp);
        frame(d, 8, r);
    endtask

    initial begin
        vecs[0]  = '{8'h00, 8'h00, 1'b1, 8'h00, 8'h00};
        vecs[1]  = '{8'h83, 8'hAA, 1'b0, 8'h00, 8'h00};
        vecs[2]  = '{8'h03, 8'h00, 1'b1, 8'hAA, 8'h00};
        vecs[3]  = '{8'h80, 8'h08, 1'b0, 8'h00, 8'h54};
        vecs[4]  = '{8'h9B, 8'h55, 1'b0, 8'h00, 8'hAA};
        vecs[5]  = '{8'h9B, 8'hAA, 1'b0, 8'h00, 8'h54};
        vecs[6]  = '{8'h00, 8'h00, 1'b1, 8'h08, 8'h54};
        vecs[7]  = '{8'h82, 8'hFF, 1'b0, 8'h00, 8'h54};
        vecs[8]  = '{8'h02, 8'h00, 1'b1, 8'h00, 8'h54};
        vecs[9]  = '{8'h81, 8'hFF, 1'b0, 8'h00, 8'h54};
        vecs[10] = '{8'h01, 8'h00, 1'b1, 8'h01, 8'h54};
        vecs[11] = '{8'h80, 8'h68, 1'b0, 8'h00, 8'h54};
        vecs[12] = '{8'h00, 8'h00, 1'b1, 8'h68, 8'h54};
        vecs[13] = '{8'h80, 8'h08, 1'b0, 8'h00, 8'h54};

        // Reset with arbitrary pin levels
        rst_n = 1'b0; ss = 1'b1; sclk = 1'b1; mosi = 1'b1; gpio = 2'b11; spare = 1'b1;
        wait_clk(3);
        check("reset_io", io_out, 8'h00);
        ss = 1'b0; sclk = 1'b0; mosi = 1'b0; gpio = 2'b01; spare = 1'b0;
        wait_clk(2);
        rst_n = 1'b1;
        wait_clk(5);
        check("post_reset_io", io_out, 8'h00);

        // Table-driven transactions
        for (int i = 0; i < 14; i++) begin
            txn(vecs[i].cmd, vecs[i].data, rdv);
            if (vecs[i].rd) begin
                check($sformatf("vec%0d_miso", i), rdv, vecs[i].exp_rd);
            end else begin
                check($sformatf("vec%0d_io_lat", i), snap4, vecs[i].exp_io);
            end
            check($sformatf("vec%0d_io", i), io_out, vecs[i].exp_io);
        end

        // Partial frame in command phase, then a full write
        frame(8'hFF, 5, dummy);
        txn(8'h83, 8'h11, dummy);
        check("partial_cmd_lat", snap4, 8'h22);
        check("partial_cmd_io", io_out, 8'h22);
        txn(8'h03, 8'h00, rdv);
        check("partial_cmd_rd", rdv, 8'h11);

        // Partial frame in data phase leaves the phase unchanged
        frame(8'h83, 8, dummy);
        frame(8'hFF, 5, dummy);
        frame(8'h2C, 8, dummy);
        check("partial_data_io", snap4, 8'h58);

        // Soft reset: CTRL=0x09 lands, then clears CTRL and OUT on the next clock
        txn(8'h80, 8'h09, dummy);
        check("srst_commit_io", snap4, 8'h58);
        check("srst_next_io", snap5, 8'h00);
        txn(8'h00, 8'h00, rdv);
        check("srst_ctrl_rd", rdv, 8'h00);
        txn(8'h03, 8'h00, rdv);
        check("srst_out_rd", rdv, 8'h00);

        // Input read
        gpio = 2'b10;
        wait_clk(4);
        txn(8'h01, 8'h00, rdv);
        check("in_rd", rdv, 8'h02);
        txn(8'h80, 8'h08, dummy);
        txn(8'h83, 8'h7F, dummy);
        check("pre_rst_io", io_out, 8'hFE);

        // Async reset between command and data frames
        frame(8'h83, 8, dummy);
        rst_n = 1'b0;
        wait_clk(3);
        check("mid_rst_io", io_out, 8'h00);
        rst_n = 1'b1;
        wait_clk(5);
        txn(8'h80, 8'h08, dummy);
        txn(8'h83, 8'h44, dummy);
        check("after_rst_io", snap4, 8'h88);
        txn(8'h03, 8'h00, rdv);
        check("after_rst_rd", rdv, 8'h44);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
